// File: rtl/color_scan_sequencer.sv
// color_scan_sequencer: capture/recognize NUM_FRAMES frames and majority-vote one colour result
module color_scan_sequencer #(
  parameter int NUM_FRAMES      = 3,
  parameter int BYTES_PER_FRAME = 19200,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_capture_start,
  input  logic        i_capture_done,
  output logic        o_ram_sel,
  output logic        o_recog_enable,
  output logic [14:0] o_bytes_per_frame,
  input  logic        i_recog_done,
  input  logic [7:0]  i_recog_color,
  output logic [7:0]  o_color,
  output logic        o_color_valid,
  output logic        o_timeout
);
  typedef enum logic [2:0] {IDLE, CAPTURE, RECOG, VOTE, DONE} state_t;
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  HALF    = 3'(NUM_FRAMES / 2);
  localparam logic [3:0]  NFR     = 4'(NUM_FRAMES);
  state_t      state_q, state_d;
  logic [2:0]  frame_q, frame_d, red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [23:0] to_q, to_d;
  logic [1:0]  arm_q, arm_d, arm_inc;
  logic [7:0]  code_q, code_d, color_q, color_d;
  logic        valid_q, valid_d, timeout_q, timeout_d, cap_q, en_q, sel_q;
  logic        accept, to_hit;
  // The arm count after this edge must read 2 before a done is trusted; this skips the stale done.
  assign arm_inc           = (arm_q == 2'd2) ? 2'd2 : arm_q + 2'd1;
  assign accept            = i_recog_done && arm_inc == 2'd2;
  assign to_hit            = to_q == TO_LAST;
  assign o_busy            = state_q != IDLE;
  assign o_bytes_per_frame = 15'(BYTES_PER_FRAME);
  assign o_capture_start   = cap_q;
  assign o_recog_enable    = en_q;
  assign o_ram_sel         = sel_q;
  assign o_color           = color_q;
  assign o_color_valid     = valid_q;
  assign o_timeout         = timeout_q;
  // Next-state, vote tally and result selection; abort overrides everything else.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    red_d     = red_q;
    grn_d     = grn_q;
    blu_d     = blu_q;
    to_d      = (state_q == CAPTURE || state_q == RECOG) ? to_q + 24'd1 : '0;
    arm_d     = (state_q == RECOG) ? arm_inc : 2'd0;
    code_d    = code_q;
    color_d   = color_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d   = CAPTURE;
        timeout_d = 1'b0;
        frame_d   = '0;
        red_d     = '0;
        grn_d     = '0;
        blu_d     = '0;
      end
      CAPTURE: if (i_capture_done) begin
        state_d = RECOG;
        to_d    = '0;
      end else if (to_hit) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        color_d   = 8'h00;
        valid_d   = 1'b1;
      end
      RECOG: if (accept) begin
        state_d = VOTE;
        code_d  = i_recog_color;
      end else if (to_hit) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        color_d   = 8'h00;
        valid_d   = 1'b1;
      end
      VOTE: begin
        red_d   = red_q + 3'(code_q == 8'd1);
        grn_d   = grn_q + 3'(code_q == 8'd2);
        blu_d   = blu_q + 3'(code_q == 8'd3);
        frame_d = frame_q + 3'd1;
        state_d = ({1'b0, frame_q} + 4'd1 < NFR) ? CAPTURE : DONE;
      end
      DONE: begin
        color_d = red_q > HALF ? 8'h01 : grn_q > HALF ? 8'h02 : blu_q > HALF ? 8'h03 : 8'h04;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_abort && state_q != IDLE) begin
      state_d   = IDLE;
      frame_d   = '0;
      red_d     = '0;
      grn_d     = '0;
      blu_d     = '0;
      to_d      = '0;
      arm_d     = '0;
      color_d   = color_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
    end
  end
  // State and registered outputs; enable/ram_sel/capture pulse follow the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      red_q     <= '0;
      grn_q     <= '0;
      blu_q     <= '0;
      to_q      <= '0;
      arm_q     <= '0;
      code_q    <= '0;
      color_q   <= 8'hF0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cap_q     <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
      to_q      <= to_d;
      arm_q     <= arm_d;
      code_q    <= code_d;
      color_q   <= color_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cap_q     <= state_d == CAPTURE && state_q != CAPTURE;
      en_q      <= state_d == RECOG;
      sel_q     <= state_d == RECOG || state_d == VOTE;
    end
  end
endmodule

// File: tb/tb_color_scan_sequencer.sv
// tb_color_scan_sequencer: directed checks of voting, arming, timeout, abort and async reset
module tb_color_scan_sequencer;
  logic        clk = 1'b0, rst, start, abort_in, cap_done, r_done;
  logic [7:0]  r_color, color;
  logic [14:0] bpf;
  logic        busy, cap_start, ram_sel, en, valid, tmo;
  int          n_chk = 0, n_fail = 0, cs_cnt = 0, v_cnt = 0;
  int          cs0, v0;

  color_scan_sequencer #(.NUM_FRAMES(3), .BYTES_PER_FRAME(19200), .TIMEOUT_CYCLES(50)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_in), .o_busy(busy),
    .o_capture_start(cap_start), .i_capture_done(cap_done), .o_ram_sel(ram_sel),
    .o_recog_enable(en), .o_bytes_per_frame(bpf), .i_recog_done(r_done),
    .i_recog_color(r_color), .o_color(color), .o_color_valid(valid), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_start) cs_cnt <= cs_cnt + 1;
    if (valid) v_cnt <= v_cnt + 1;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic meas(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                      input logic [7:0] exp_col);
    logic [7:0] codes [3];
    codes = '{c0, c1, c2};
    cs0 = cs_cnt;
    v0  = v_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int f = 0; f < 3; f++) begin
      chk("capture_pulse", cap_start, 1);
      repeat (10) tick;
      chk("ram_sel_capture", ram_sel, 0);
      cap_done = 1'b1;
      r_done   = 1'b1;
      r_color  = codes[f];
      tick;
      cap_done = 1'b0;
      chk("enable_rise", en, 1);
      chk("ram_sel_recog", ram_sel, 1);
      tick;
      chk("arm_masks_done", en, 1);
      tick;
      chk("vote_after_2", en, 0);
      r_done = 1'b0;
      tick;
    end
    chk("done_no_valid_yet", valid, 0);
    tick;
    chk("valid_pulse", valid, 1);
    chk("voted_color", color, exp_col);
    chk("timeout_clear", tmo, 0);
    chk("idle_after_done", busy, 0);
    tick;
    chk("valid_one_cycle", valid, 0);
    chk("capture_pulses", cs_cnt - cs0, 3);
    chk("valid_pulses", v_cnt - v0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort_in = 1'b0; cap_done = 1'b0; r_done = 1'b0; r_color = 8'h00;
    repeat (2) tick;
    chk("rst_color", color, 8'hF0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cap_start", cap_start, 0);
    chk("rst_enable", en, 0);
    chk("rst_ram_sel", ram_sel, 0);
    chk("bytes_per_frame", bpf, 15'd19200);
    rst = 1'b0;
    tick;
    meas(8'd1, 8'd1, 8'd3, 8'h01);
    meas(8'd1, 8'd2, 8'd3, 8'h04);
    meas(8'd2, 8'd0, 8'd2, 8'h02);
    v0 = v_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    cap_done = 1'b1;
    r_done   = 1'b1;
    r_color  = 8'd1;
    tick;
    cap_done = 1'b0;
    tick;
    abort_in = 1'b1;
    tick;
    abort_in = 1'b0;
    r_done   = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_enable", en, 0);
    chk("abort_ram_sel", ram_sel, 0);
    chk("abort_no_valid", valid, 0);
    chk("abort_color_kept", color, 8'h02);
    repeat (2) tick;
    chk("abort_no_pulse", v_cnt - v0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (19) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (29) tick;
    chk("to_busy_49", busy, 1);
    chk("to_flag_49", tmo, 0);
    tick;
    chk("to_flag", tmo, 1);
    chk("to_color", color, 8'h00);
    chk("to_valid", valid, 1);
    chk("to_busy", busy, 0);
    chk("to_enable", en, 0);
    chk("to_ram_sel", ram_sel, 0);
    tick;
    chk("to_valid_drop", valid, 0);
    chk("to_sticky", tmo, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("to_cleared", tmo, 0);
    chk("to_restart_busy", busy, 1);
    abort_in = 1'b1;
    tick;
    abort_in = 1'b0;
    chk("abort_capture", busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    cap_done = 1'b1;
    tick;
    cap_done = 1'b0;
    chk("pre_rst_enable", en, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_enable", en, 0);
    chk("arst_ram_sel", ram_sel, 0);
    chk("arst_color", color, 8'hF0);
    chk("arst_busy", busy, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
